// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM states, mode indices, clog2.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Mode index = {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int unsigned spi_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period tick generator with sync clear; qualifies each tick as a
// leading or trailing edge from the current sclk level and the latched cpol.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic cpol,
    input  logic sclk,
    output logic tick_c,
    output logic lead_c,
    output logic trail_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? spi_clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c  = (cnt == CNT_W'(CLK_DIV - 1));
    assign lead_c  = tick_c && (sclk == cpol);
    assign trail_c = tick_c && (sclk != cpol);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: all CPOL/CPHA modes, MSB/LSB-first, full duplex,
// multiple chip selects. Define SPI_LOOPBACK_EN to feed mosi back into the receiver.
module spi_master
    import spi_pkg::*;
#(
    parameter  int unsigned DATA_W  = 12,
    parameter  int unsigned CLK_DIV = 5,
    parameter  int unsigned NUM_CS  = 1,
    localparam int unsigned CS_W    = (NUM_CS > 1) ? spi_clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] din,
    input  logic              miso,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int unsigned EDGES  = 2 * DATA_W;
    localparam int unsigned EDGE_W = spi_clog2(EDGES + 1);

    spi_state_t        state;
    logic              cpol_q, cpha_q, lsb_q;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [EDGE_W-1:0] ecnt;

    logic tick_c, lead_c, trail_c;
    logic edge_c, sample_c, shift_c, rx_bit_c, tx_bit_c;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .cpol    (cpol_q),
        .sclk    (sclk),
        .tick_c  (tick_c),
        .lead_c  (lead_c),
        .trail_c (trail_c)
    );

`ifdef SPI_LOOPBACK_EN
    assign rx_bit_c = mosi;
`else
    assign rx_bit_c = miso;
`endif

    // The tick ending SETUP is the first SCLK edge; XFER stops toggling after the last edge.
    assign edge_c   = tick_c && ((state == SETUP) ||
                                 ((state == XFER) && (ecnt != EDGE_W'(EDGES))));
    assign sample_c = edge_c && (cpha_q ? trail_c : lead_c);
    assign shift_c  = edge_c && (cpha_q ? lead_c
                                        : (trail_c && (ecnt != EDGE_W'(EDGES - 1))));
    assign tx_bit_c = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            cs_n   <= '1;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            lsb_q  <= 1'b0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            ecnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (start) begin
                        state  <= SETUP;
                        busy   <= 1'b1;
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        lsb_q  <= lsb_first;
                        // Out-of-range selects shift the low bit away, leaving all high.
                        cs_n   <= ~(NUM_CS'(1) << cs_sel);
                        ecnt   <= '0;
                        rx_sh  <= '0;
                        if (cpha) begin
                            tx_sh <= din;
                        end else begin
                            mosi  <= lsb_first ? din[0] : din[DATA_W-1];
                            tx_sh <= lsb_first ? (din >> 1) : (din << 1);
                        end
                    end
                end
                SETUP: if (tick_c) state <= XFER;
                XFER:  if (tick_c && (ecnt == EDGE_W'(EDGES))) state <= HOLD;
                HOLD: begin
                    if (tick_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        dout  <= rx_sh;
                        cs_n  <= '1;
                    end
                end
            endcase

            if (edge_c) begin
                sclk <= ~sclk;
                ecnt <= ecnt + EDGE_W'(1);
            end
            if (sample_c) begin
                rx_sh <= lsb_q ? {rx_bit_c, rx_sh[DATA_W-1:1]}
                               : {rx_sh[DATA_W-2:0], rx_bit_c};
            end
            if (shift_c) begin
                mosi  <= tx_bit_c;
                tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
            end
        end
    end

endmodule
